// File: rtl/autoconfig_pkg.sv
// Shared constants, register map and state types for the Zorro II Autoconfig initiator.
package autoconfig_pkg;

  localparam logic [7:0] CFG_SPACE    = 8'hE8;
  localparam logic [3:0] IO_NIBBLE    = 4'hE;

  localparam logic [7:0] IDX_TYPE     = 8'h00;
  localparam logic [7:0] IDX_SIZE     = 8'h01;
  localparam logic [7:0] IDX_PROD_HI  = 8'h02;
  localparam logic [7:0] IDX_PROD_LO  = 8'h03;
  localparam logic [7:0] IDX_MFG_3    = 8'h08;
  localparam logic [7:0] IDX_MFG_2    = 8'h09;
  localparam logic [7:0] IDX_MFG_1    = 8'h0A;
  localparam logic [7:0] IDX_MFG_0    = 8'h0B;
  localparam logic [7:0] IDX_BASE_HI  = 8'h24;
  localparam logic [7:0] IDX_BASE_LO  = 8'h25;
  localparam logic [7:0] IDX_SHUTUP   = 8'h26;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DECIDE, S_WRITE, S_REPORT, S_FINISH
  } seq_state_e;

  typedef enum logic [2:0] {
    B_IDLE, B_ADDR, B_WAIT, B_HOLD, B_REC
  } bus_state_e;

  function automatic logic [7:0] read_idx(input logic [2:0] n);
    case (n)
      3'd0:    return IDX_TYPE;
      3'd1:    return IDX_SIZE;
      3'd2:    return IDX_PROD_HI;
      3'd3:    return IDX_PROD_LO;
      3'd4:    return IDX_MFG_3;
      3'd5:    return IDX_MFG_2;
      3'd6:    return IDX_MFG_1;
      default: return IDX_MFG_0;
    endcase
  endfunction

  // Zero marks an unsupported size code.
  function automatic logic [4:0] size_units(input logic [2:0] size);
    case (size)
      3'd1:    return 5'd1;
      3'd2:    return 5'd2;
      3'd3:    return 5'd4;
      3'd4:    return 5'd8;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/zorro_bus_master.sv
// Single Zorro bus cycle engine for the configuration space: one read or write per request.
module zorro_bus_master
  import autoconfig_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        rw,
  input  logic [7:0]  idx,
  input  logic [3:0]  wdata,
  output logic        ack,
  output logic [3:0]  rdata,
  output logic        timeout,
  output logic [22:0] ADDR,
  output logic        AS_n,
  output logic        UDS_n,
  output logic        RW,
  output logic [3:0]  DOUT,
  input  logic [3:0]  DIN,
  input  logic        DTACK
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  bus_state_e    state_q, state_d;
  logic [22:0]   addr_q, addr_d;
  logic          rw_q, rw_d, as_n_q, as_n_d, rec_q, rec_d;
  logic [3:0]    dout_q, dout_d, rdata_q, rdata_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          ack_q, ack_d, timeout_q, timeout_d;
  logic          launch;

  // A new cycle may start from idle, or straight out of recovery once two
  // strobe-high cycles have passed and the responder has released DTACK.
  assign launch = req && ((state_q == B_IDLE) || (state_q == B_REC && rec_q && !DTACK));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    dout_d    = dout_q;
    as_n_d    = as_n_q;
    rec_d     = rec_q;
    tcnt_d    = tcnt_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      B_ADDR: begin
        as_n_d  = 1'b0;
        tcnt_d  = '0;
        state_d = B_WAIT;
      end
      B_WAIT: begin
        if (DTACK) begin
          rdata_d = DIN;
          ack_d   = 1'b1;
          state_d = B_HOLD;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = B_HOLD;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      B_HOLD: begin
        as_n_d  = 1'b1;
        rec_d   = 1'b0;
        state_d = B_REC;
      end
      B_REC: begin
        if (!rec_q)      rec_d   = 1'b1;
        else if (!DTACK) state_d = B_IDLE;
      end
      default: ;
    endcase
    if (launch) begin
      addr_d  = {CFG_SPACE, 7'h00, idx};
      rw_d    = rw;
      dout_d  = rw ? '0 : wdata;
      state_d = B_ADDR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= B_IDLE;
      addr_q    <= '0;
      rw_q      <= 1'b1;
      dout_q    <= '0;
      as_n_q    <= 1'b1;
      rec_q     <= 1'b0;
      tcnt_q    <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      dout_q    <= dout_d;
      as_n_q    <= as_n_d;
      rec_q     <= rec_d;
      tcnt_q    <= tcnt_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
    end
  end

  assign ADDR    = addr_q;
  assign AS_n    = as_n_q;
  assign UDS_n   = as_n_q;
  assign RW      = rw_q;
  assign DOUT    = dout_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign timeout = timeout_q;

endmodule

// File: rtl/autoconfig_host.sv
// Autoconfig sequencer: reads each board's identity, allocates an I/O base or shuts it up, reports.
module autoconfig_host
  import autoconfig_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_BOARDS     = 4,
  parameter logic [3:0]  BASE_FIRST     = 4'h9,
  localparam int unsigned BCW           = $clog2(MAX_BOARDS + 1)
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           start,
  output logic [22:0]    ADDR,
  output logic           AS_n,
  output logic           UDS_n,
  output logic           RW,
  output logic [3:0]     DOUT,
  input  logic [3:0]     DIN,
  input  logic           DTACK,
  output logic           CFGOUT_n,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [BCW-1:0] board_count,
  output logic           cfg_valid,
  output logic [15:0]    cfg_mfg,
  output logic [7:0]     cfg_prod,
  output logic [7:0]     cfg_base,
  output logic           cfg_shutup
);

  seq_state_e     state_q, state_d;
  logic [2:0]     rd_cnt_q, rd_cnt_d;
  logic [1:0]     type_q, type_d;
  logic [2:0]     size_q, size_d;
  logic [7:0]     prod_q, prod_d;
  logic [15:0]    mfg_q, mfg_d;
  logic [4:0]     next_free_q, next_free_d, alloc_end_q, alloc_end_d;
  logic [3:0]     base_q, base_d;
  logic           fit_q, fit_d, wr_step_q, wr_step_d;
  logic           busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [BCW-1:0] count_q, count_d;
  logic           valid_q, valid_d, shutup_q, shutup_d;
  logic [15:0]    rmfg_q, rmfg_d;
  logic [7:0]     rprod_q, rprod_d, rbase_q, rbase_d;

  logic       req, rw, ack, timeout;
  logic [7:0] idx;
  logic [3:0] wdata, rdata, nib;
  logic [4:0] units, base;

  zorro_bus_master #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_bus (
    .clk(CLK), .rst(RESET), .req(req), .rw(rw), .idx(idx), .wdata(wdata),
    .ack(ack), .rdata(rdata), .timeout(timeout),
    .ADDR(ADDR), .AS_n(AS_n), .UDS_n(UDS_n), .RW(RW), .DOUT(DOUT),
    .DIN(DIN), .DTACK(DTACK)
  );

  assign nib   = (rd_cnt_q == 3'd0) ? rdata : ~rdata;
  assign units = size_units(size_q);
  assign base  = (next_free_q + units - 5'd1) & ~(units - 5'd1);

  always_comb begin
    state_d = state_q;  rd_cnt_d = rd_cnt_q;  type_d = type_q;  size_d = size_q;
    prod_d = prod_q;  mfg_d = mfg_q;  next_free_d = next_free_q;  alloc_end_d = alloc_end_q;
    base_d = base_q;  fit_d = fit_q;  wr_step_d = wr_step_q;  busy_d = busy_q;
    done_d = done_q;  error_d = error_q;  count_d = count_q;  valid_d = 1'b0;
    shutup_d = shutup_q;  rmfg_d = rmfg_q;  rprod_d = rprod_q;  rbase_d = rbase_q;
    req = 1'b0;  rw = 1'b1;  idx = read_idx(rd_cnt_q);  wdata = '0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_READ;  busy_d = 1'b1;  done_d = 1'b0;  error_d = 1'b0;
        count_d = '0;  rd_cnt_d = '0;  next_free_d = {1'b0, BASE_FIRST};
      end
      S_READ: begin
        req = 1'b1;
        if (ack) begin
          case (rd_cnt_q)
            3'd0: type_d = nib[3:2];
            3'd1: size_d = nib[2:0];
            3'd2: prod_d[7:4] = nib;
            3'd3: prod_d[3:0] = nib;
            3'd4: mfg_d[15:12] = nib;
            3'd5: mfg_d[11:8] = nib;
            3'd6: mfg_d[7:4] = nib;
            default: mfg_d[3:0] = nib;
          endcase
          rd_cnt_d = rd_cnt_q + 3'd1;
          if (rd_cnt_q == 3'd7) state_d = S_DECIDE;
        end else if (timeout) begin
          // Silence on the type read means the chain is exhausted, not a fault.
          error_d = (rd_cnt_q != 3'd0);
          state_d = S_FINISH;
        end
      end
      S_DECIDE: begin
        fit_d = (type_q == 2'b11) && (units != 5'd0) &&
                ({1'b0, base} + {1'b0, units} <= 6'd16);
        base_d      = base[3:0];
        alloc_end_d = base + units;
        wr_step_d   = 1'b0;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        req = 1'b1;
        rw  = 1'b0;
        if (!fit_q)         idx = IDX_SHUTUP;
        else if (wr_step_q) begin idx = IDX_BASE_HI; wdata = IO_NIBBLE; end
        else                begin idx = IDX_BASE_LO; wdata = base_q;    end
        if (ack) begin
          if (fit_q && !wr_step_q) begin
            wr_step_d = 1'b1;
          end else begin
            state_d  = S_REPORT;
            valid_d  = 1'b1;
            count_d  = count_q + BCW'(1);
            rmfg_d   = mfg_q;
            rprod_d  = prod_q;
            shutup_d = !fit_q;
            rbase_d  = fit_q ? {IO_NIBBLE, base_q} : '0;
            if (fit_q) next_free_d = alloc_end_q;
          end
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_REPORT: state_d = (count_q == BCW'(MAX_BOARDS)) ? S_FINISH : S_READ;
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;  rd_cnt_q <= '0;  type_q <= '0;  size_q <= '0;
      prod_q <= '0;  mfg_q <= '0;  next_free_q <= {1'b0, BASE_FIRST};  alloc_end_q <= '0;
      base_q <= '0;  fit_q <= 1'b0;  wr_step_q <= 1'b0;  busy_q <= 1'b0;
      done_q <= 1'b0;  error_q <= 1'b0;  count_q <= '0;  valid_q <= 1'b0;
      shutup_q <= 1'b0;  rmfg_q <= '0;  rprod_q <= '0;  rbase_q <= '0;
    end else begin
      state_q <= state_d;  rd_cnt_q <= rd_cnt_d;  type_q <= type_d;  size_q <= size_d;
      prod_q <= prod_d;  mfg_q <= mfg_d;  next_free_q <= next_free_d;  alloc_end_q <= alloc_end_d;
      base_q <= base_d;  fit_q <= fit_d;  wr_step_q <= wr_step_d;  busy_q <= busy_d;
      done_q <= done_d;  error_q <= error_d;  count_q <= count_d;  valid_q <= valid_d;
      shutup_q <= shutup_d;  rmfg_q <= rmfg_d;  rprod_q <= rprod_d;  rbase_q <= rbase_d;
    end
  end

  assign CFGOUT_n    = ~busy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign board_count = count_q;
  assign cfg_valid   = valid_q;
  assign cfg_mfg     = rmfg_q;
  assign cfg_prod    = rprod_q;
  assign cfg_base    = rbase_q;
  assign cfg_shutup  = shutup_q;

endmodule
